gauss_conv_mac: RTL and testbench

- Downstream consumer of the Gaussian kernel generator.
- Captures the generated kernel and its weight sum. Then, for each incoming pixel window, computes the normalised weighted sum `round(Σ k[y][x]·p[y][x] / sum)` and emits one 8-bit filtered pixel.
- Uses one multiply-accumulate per cycle followed by a 32-cycle restoring divider.
- Sits between the window buffer (upstream) and the FAST corner scoring stage (downstream).

---
 rtl/gauss_conv_mac.sv | 154 +++++++++++++++
 tb/tb_gauss_conv_mac.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/gauss_conv_mac.sv
// Gaussian convolution MAC: one tap per cycle, then a 32-step restoring divide by the kernel weight sum.
// Build option GAUSS_ROUND_EN: adds sum>>1 to the dividend for round-half-up (truncation otherwise).
module gauss_conv_mac #(
  parameter  int MAX_KERNAL = 7,
  parameter  int ACC_W      = 32,
  localparam int KW         = $clog2(MAX_KERNAL)
) (
  input  logic                                         clk,
  input  logic                                         n_rst,
  input  logic                                         kernel_load,
  input  logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0]   kernel,
  input  logic [31:0]                                  kernel_sum,
  input  logic [KW-1:0]                                kernel_size,
  input  logic                                         win_valid,
  output logic                                         win_ready,
  input  logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0]   window,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [7:0]                                   out_pixel,
  output logic                                         div_zero,
  output logic                                         busy
);

  localparam int CW = $clog2(ACC_W);

  typedef enum logic [1:0] {IDLE, MAC, DIV, OUT} state_t;
  state_t state, state_nxt;

  logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] kern_q, win_q;
  logic [31:0]      sum_q;
  logic [KW-1:0]    ksize_q, k_last, tx, ty;
  logic             kernel_valid;
  logic [ACC_W-1:0] acc, dvd, rem, acc_sum, round_add, rem_nxt, quo_nxt;
  logic [ACC_W:0]   trial, sum_ext, diff;
  logic [15:0]      prod;
  logic [CW-1:0]    div_cnt;
  logic             accept, last_tap, last_div, qbit, sum_zero;

  function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
    if (k == '0)                      return KW'(1);
    else if (int'(k) > MAX_KERNAL)    return KW'(MAX_KERNAL);
    else                              return k;
  endfunction

  function automatic logic [7:0] sat8(input logic [ACC_W-1:0] q);
    return (q > ACC_W'(255)) ? 8'hFF : q[7:0];
  endfunction

  assign win_ready = (state == IDLE) && kernel_valid && !kernel_load;
  assign accept    = win_valid && win_ready;
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  assign k_last   = ksize_q - KW'(1);
  assign last_tap = (tx == k_last) && (ty == k_last);
  assign last_div = (div_cnt == CW'(ACC_W - 1));
  assign sum_zero = (sum_q == '0);

  assign prod    = {8'd0, kern_q[ty][tx]} * {8'd0, win_q[ty][tx]};
  assign acc_sum = acc + ACC_W'(prod);
`ifdef GAUSS_ROUND_EN
  assign round_add = ACC_W'(sum_q >> 1);
`else
  assign round_add = '0;
`endif

  // Restoring divide step: remainder always stays below the divisor, so it fits ACC_W bits
  assign trial   = {rem, dvd[ACC_W-1]};
  assign sum_ext = (ACC_W+1)'(sum_q);
  assign qbit    = (trial >= sum_ext);
  assign diff    = trial - sum_ext;
  assign rem_nxt = qbit ? diff[ACC_W-1:0] : trial[ACC_W-1:0];
  assign quo_nxt = sum_zero ? '0 : {dvd[ACC_W-2:0], qbit};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)    state_nxt = MAC;
      MAC:  if (last_tap)  state_nxt = DIV;
      DIV:  if (last_div)  state_nxt = OUT;
      OUT:  if (out_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      kernel_valid <= 1'b0;
      kern_q       <= '0;
      sum_q        <= '0;
      ksize_q      <= '0;
      tx           <= '0;
      ty           <= '0;
      div_cnt      <= '0;
      out_pixel    <= '0;
      div_zero     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (kernel_load) begin
            kern_q       <= kernel;
            sum_q        <= kernel_sum;
            ksize_q      <= clamp_k(kernel_size);
            kernel_valid <= 1'b1;
          end
          if (accept) begin
            tx      <= '0;
            ty      <= '0;
            div_cnt <= '0;
          end
        end
        MAC: begin
          if (tx == k_last) begin
            tx <= '0;
            ty <= ty + KW'(1);
          end else begin
            tx <= tx + KW'(1);
          end
        end
        DIV: begin
          div_cnt <= div_cnt + CW'(1);
          if (sum_zero) div_zero <= 1'b1;
          if (last_div) out_pixel <= sat8(quo_nxt);
        end
        default: ;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always reloaded before use
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (accept) begin
        win_q <= window;
        acc   <= '0;
      end
      MAC: begin
        acc <= acc_sum;
        if (last_tap) begin
          dvd <= acc_sum + round_add;
          rem <= '0;
        end
      end
      DIV: begin
        dvd <= quo_nxt;
        if (!sum_zero) rem <= rem_nxt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gauss_conv_mac.sv
// Directed bench for gauss_conv_mac with hand-computed expected pixels and latencies.
module tb_gauss_conv_mac;
  localparam int MK = 7;

`ifdef GAUSS_ROUND_EN
  localparam int EXP_CTR = 53;
`else
  localparam int EXP_CTR = 52;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst, kernel_load, win_valid, out_ready;
  logic [MK-1:0][MK-1:0][7:0] kernel, window;
  logic [31:0] kernel_sum;
  logic [2:0]  kernel_size;
  logic win_ready, out_valid, div_zero, busy;
  logic [7:0] out_pixel;

  int n_vec = 0;
  int n_err = 0;
  logic [MK-1:0][MK-1:0][7:0] k_a, k_ones, w_uni, w_ctr, w_full;

  gauss_conv_mac #(.MAX_KERNAL(MK), .ACC_W(32)) dut (
    .clk(clk), .n_rst(n_rst), .kernel_load(kernel_load), .kernel(kernel),
    .kernel_sum(kernel_sum), .kernel_size(kernel_size), .win_valid(win_valid),
    .win_ready(win_ready), .window(window), .out_valid(out_valid),
    .out_ready(out_ready), .out_pixel(out_pixel), .div_zero(div_zero), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_kernel(input logic [MK-1:0][MK-1:0][7:0] k, input logic [31:0] s,
                             input logic [2:0] sz);
    @(negedge clk);
    kernel = k; kernel_sum = s; kernel_size = sz; kernel_load = 1'b1;
    @(posedge clk); #1;
    kernel_load = 1'b0;
  endtask

  task automatic accept_window(input logic [MK-1:0][MK-1:0][7:0] w, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    window = w; win_valid = 1'b1;
    while (!win_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(win_ready), 1);
    @(posedge clk); #1;
    win_valid = 1'b0;
  endtask

  task automatic wait_out(input int start, input string tag, output int lat);
    lat = start;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 1);
  endtask

  initial begin
    int lat;
    logic seen;
    logic stable;

    k_a = '0; k_ones = '0; w_ctr = '0;
    for (int y = 0; y < MK; y++)
      for (int x = 0; x < MK; x++) begin
        w_uni[y][x]  = 8'd200;
        w_full[y][x] = 8'd255;
        k_ones[y][x] = 8'd1;
      end
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++)
        k_a[y][x] = (x == 1 && y == 1) ? 8'd100 : ((x == 1 || y == 1) ? 8'd60 : 8'd36);
    w_ctr[1][1] = 8'd255;

    n_rst = 1'b0; kernel_load = 1'b0; win_valid = 1'b0; out_ready = 1'b1;
    kernel = '0; window = '0; kernel_sum = '0; kernel_size = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_pixel", 32'(out_pixel), 0);
    chk("rst_div_zero",  32'(div_zero), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_win_ready", 32'(win_ready), 0);
    n_rst = 1'b1;

    // No kernel captured yet: windows must be refused
    window = w_uni; win_valid = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      seen = seen | win_ready | out_valid;
    end
    chk("nokernel_ready_or_valid", 32'(seen), 0);
    win_valid = 1'b0;

    // 3x3 kernel, uniform window
    load_kernel(k_a, 32'd484, 3'd3);
    accept_window(w_uni, "uni");
    wait_out(0, "uni", lat);
    chk("uni_latency", 32'(lat), 41);
    chk("uni_pixel",   32'(out_pixel), 200);
    @(posedge clk); #1;
    chk("uni_valid_drop", 32'(out_valid), 0);

    // Centre impulse exercises the rounding choice
    accept_window(w_ctr, "ctr");
    wait_out(0, "ctr", lat);
    chk("ctr_pixel", 32'(out_pixel), EXP_CTR);
    @(posedge clk); #1;

    // 7x7 all-ones kernel, full-scale window, then backpressure
    load_kernel(k_ones, 32'd49, 3'd7);
    out_ready = 1'b0;
    accept_window(w_full, "full");
    wait_out(0, "full", lat);
    chk("full_latency", 32'(lat), 81);
    chk("full_pixel",   32'(out_pixel), 255);
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid || out_pixel != 8'd255 || win_ready) stable = 1'b0;
    end
    chk("hold_stable", 32'(stable), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release", 32'(out_valid), 0);

    // Zero weight sum
    load_kernel(k_a, 32'd0, 3'd3);
    accept_window(w_uni, "zsum");
    wait_out(0, "zsum", lat);
    chk("zsum_pixel",    32'(out_pixel), 0);
    chk("zsum_div_zero", 32'(div_zero), 1);
    @(posedge clk); #1;

    // kernel_load during MAC must not disturb the window in flight
    load_kernel(k_a, 32'd484, 3'd3);
    accept_window(w_ctr, "midload");
    kernel = k_ones; kernel_sum = 32'd9; kernel_size = 3'd3; kernel_load = 1'b1;
    @(posedge clk); #1;
    kernel_load = 1'b0;
    wait_out(1, "midload", lat);
    chk("midload_pixel",  32'(out_pixel), EXP_CTR);
    chk("div_zero_stick", 32'(div_zero), 1);
    @(posedge clk); #1;
    accept_window(w_uni, "oldkern");
    wait_out(0, "oldkern", lat);
    chk("oldkern_pixel", 32'(out_pixel), 200);
    @(posedge clk); #1;

    // Reset while dividing
    accept_window(w_uni, "rstdiv");
    repeat (12) @(posedge clk);
    #1;
    chk("rstdiv_busy_before", 32'(busy), 1);
    n_rst = 1'b0;
    @(posedge clk); #1;
    chk("rstdiv_busy",      32'(busy), 0);
    chk("rstdiv_out_valid", 32'(out_valid), 0);
    chk("rstdiv_win_ready", 32'(win_ready), 0);
    chk("rstdiv_div_zero",  32'(div_zero), 0);
    n_rst = 1'b1;
    window = w_uni; win_valid = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | win_ready;
    end
    chk("rstdiv_needs_kernel", 32'(seen), 0);
    win_valid = 1'b0;
    load_kernel(k_a, 32'd484, 3'd3);
    accept_window(w_uni, "after_rst");
    wait_out(0, "after_rst", lat);
    chk("after_rst_pixel", 32'(out_pixel), 200);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
